// File: rtl/ps2_byte_receiver_pkg.sv
// Shared PS/2 definitions: receiver FSM encodings, scancodes of interest
// and the odd-parity rule used on every frame.
package ps2_byte_receiver_pkg;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_DATA_ENC   = 2'd1;
  localparam logic [1:0] ST_PARITY_ENC = 2'd2;
  localparam logic [1:0] ST_STOP_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_DATA   = ST_DATA_ENC,
    ST_PARITY = ST_PARITY_ENC,
    ST_STOP   = ST_STOP_ENC
  } ps2_state_e;

  localparam logic [7:0] RELEASE_PREFIX = 8'hF0;
  localparam logic [7:0] SPACE_SCANCODE = 8'h29;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_byte_receiver_line_filter.sv
// Two-flop synchronizer, run-length glitch filter and falling-edge tick
// for one raw PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw_in,
  output logic fall_tick
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q,  filt_d;
  logic             fall_q,  fall_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // The counter only runs while the synced line disagrees with the filtered
  // level; any agreeing sample restarts the run.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fall_tick = fall_q;

endmodule

// File: rtl/ps2_byte_receiver.sv
// Receive-only PS/2 deserializer: frames start/8 data/parity/stop bits into
// validated scancode bytes, flagging parity, stop-bit and timeout errors.
module ps2_byte_receiver
  import ps2_byte_receiver_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       inclock,
  input  logic       resetn,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic fall_tick;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk       (inclock),
    .resetn    (resetn),
    .raw_in    (ps2_clock),
    .fall_tick (fall_tick)
  );

  logic             data_s1_q, data_s1_d;
  logic             data_s2_q, data_s2_d;
  ps2_state_e       state_q,   state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q,   shift_d;
  logic             par_q,     par_d;
  logic [TMO_W-1:0] tmo_q,     tmo_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_en_q,   rx_en_d;
  logic             par_err_q, par_err_d;
  logic             frm_err_q, frm_err_d;

  always_comb begin
    data_s1_d = ps2_data;
    data_s2_d = data_s1_q;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = '0;
    rx_data_d = rx_data_q;
    rx_en_d   = 1'b0;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;

    if (state_q == ST_IDLE) begin
      if (fall_tick && !data_s2_q) begin
        state_d   = ST_DATA;
        bit_cnt_d = '0;
      end
    // Timeout is checked ahead of fall_tick so it wins a same-cycle tie.
    end else if (tmo_q == TMO_LIMIT) begin
      frm_err_d = 1'b1;
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (fall_tick) begin
      unique case (state_q)
        ST_DATA: begin
          shift_d   = {data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = data_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!data_s2_q) begin
            frm_err_d = 1'b1;
          end else if (!odd_parity_ok(shift_q, par_q)) begin
            par_err_d = 1'b1;
          end else begin
            rx_data_d = shift_q;
            rx_en_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge inclock) begin
    if (!resetn) begin
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      rx_data_q <= 8'h00;
      rx_en_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      data_s1_q <= data_s1_d;
      data_s2_q <= data_s2_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      rx_data_q <= rx_data_d;
      rx_en_q   <= rx_en_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign received_data    = rx_data_q;
  assign received_data_en = rx_en_q;
  assign parity_error     = par_err_q;
  assign frame_error      = frm_err_q;

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Bench for ps2_byte_receiver: directed frame table, hand-written corner
// sequences, then random frames checked against a frame-level model.
module tb_ps2_byte_receiver;
  import ps2_byte_receiver_pkg::*;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 4500;
  localparam int LAT            = 2 + FILTER_LEN + 1;
  localparam int FAST_HALF      = 32;
  localparam int SLOW_HALF      = 2000;
  localparam int N_RANDOM       = 24;

  logic       inclock   = 1'b0;
  logic       resetn    = 1'b0;
  logic       ps2_clock = 1'b1;
  logic       ps2_data  = 1'b1;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       parity_error;
  logic       frame_error;

  ps2_byte_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .inclock          (inclock),
    .resetn           (resetn),
    .ps2_clock        (ps2_clock),
    .ps2_data         (ps2_data),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .parity_error     (parity_error),
    .frame_error      (frame_error)
  );

  always #10 inclock = ~inclock;

  typedef enum int {EV_DATA = 0, EV_PERR = 1, EV_FERR = 2} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         half;
    ev_kind_e   kind;
    logic [7:0] rd;
  } vec_t;

  ev_t evq[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge inclock) cyc <= cyc + 1;

  // Every high cycle of any output pulse is logged with the posedge count.
  always @(negedge inclock) begin
    if (received_data_en) evq.push_back('{kind: EV_DATA, data: received_data, cyc: cyc});
    if (parity_error)     evq.push_back('{kind: EV_PERR, data: received_data, cyc: cyc});
    if (frame_error)      evq.push_back('{kind: EV_FERR, data: received_data, cyc: cyc});
  end

  initial begin
    #(20 * 150000);
    $display("FAIL watchdog: simulation did not complete within 150000 cycles");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge inclock);
  endtask

  // Drives the first nbits of a device frame (start, d0..d7, parity, stop).
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int half, input int nbits, output int last_fall);
    logic [10:0] fr;
    fr = {s, p, d, 1'b0};
    last_fall = cyc;
    for (int i = 0; i < nbits; i++) begin
      @(negedge inclock);
      ps2_data = fr[i];
      wait_cycles(half);
      ps2_clock = 1'b0;
      last_fall = cyc;
      wait_cycles(half);
      ps2_clock = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic check_frame(input string name, input ev_kind_e kind, input logic [7:0] data,
                             input logic [7:0] rd, input int ref_cyc, input int lat);
    wait_cycles(30);
    chk({name, ".pulses"}, evq.size(), 1);
    if (evq.size() >= 1) begin
      chk({name, ".kind"}, int'(evq[0].kind), int'(kind));
      chk({name, ".latency"}, evq[0].cyc - ref_cyc, lat);
      if (kind == EV_DATA) chk({name, ".data"}, int'(evq[0].data), int'(data));
    end
    chk({name, ".received_data"}, int'(received_data), int'(rd));
    evq.delete();
  endtask

  vec_t       vecs[6];
  int         last_fall;
  logic [7:0] model_rd;
  logic [7:0] rd_byte;
  logic       rp, rs;
  ev_kind_e   rk;

  initial begin
    vecs[0] = '{data: SPACE_SCANCODE, par: 1'b0, stop: 1'b1, half: SLOW_HALF, kind: EV_DATA, rd: 8'h29};
    vecs[1] = '{data: RELEASE_PREFIX, par: 1'b1, stop: 1'b1, half: FAST_HALF, kind: EV_DATA, rd: 8'hF0};
    vecs[2] = '{data: SPACE_SCANCODE, par: 1'b0, stop: 1'b1, half: FAST_HALF, kind: EV_DATA, rd: 8'h29};
    vecs[3] = '{data: 8'h1C,          par: 1'b0, stop: 1'b1, half: FAST_HALF, kind: EV_DATA, rd: 8'h1C};
    vecs[4] = '{data: SPACE_SCANCODE, par: 1'b1, stop: 1'b1, half: FAST_HALF, kind: EV_PERR, rd: 8'h1C};
    vecs[5] = '{data: RELEASE_PREFIX, par: 1'b1, stop: 1'b0, half: FAST_HALF, kind: EV_FERR, rd: 8'h1C};

    wait_cycles(4);
    chk("reset.received_data", int'(received_data), 0);
    chk("reset.pulses", int'({received_data_en, parity_error, frame_error}), 0);
    resetn = 1'b1;
    wait_cycles(20);
    chk("post_reset.events", evq.size(), 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].half, 11, last_fall);
      check_frame($sformatf("vec%0d", i), vecs[i].kind, vecs[i].data, vecs[i].rd, last_fall, LAT);
    end

    // Clocking stops after start + 4 data bits; the frame must time out.
    send_frame(8'hA5, 1'b1, 1'b1, FAST_HALF, 5, last_fall);
    wait_cycles(TIMEOUT_CYCLES + 10);
    check_frame("timeout", EV_FERR, 8'h00, 8'h1C, last_fall, LAT + TIMEOUT_CYCLES + 1);
    send_frame(8'h1C, 1'b0, 1'b1, FAST_HALF, 11, last_fall);
    check_frame("after_timeout", EV_DATA, 8'h1C, 8'h1C, last_fall, LAT);

    // Short low glitch with data low while idle must not start a frame.
    @(negedge inclock);
    ps2_data = 1'b0;
    wait_cycles(5);
    ps2_clock = 1'b0;
    wait_cycles(3);
    ps2_clock = 1'b1;
    wait_cycles(30);
    chk("glitch.events", evq.size(), 0);
    ps2_data = 1'b1;
    wait_cycles(5);
    send_frame(SPACE_SCANCODE, 1'b0, 1'b1, FAST_HALF, 11, last_fall);
    check_frame("after_glitch", EV_DATA, 8'h29, 8'h29, last_fall, LAT);

    // One-cycle reset in the middle of a frame.
    send_frame(8'h5A, 1'b1, 1'b1, FAST_HALF, 4, last_fall);
    @(negedge inclock);
    resetn = 1'b0;
    @(negedge inclock);
    resetn = 1'b1;
    chk("midreset.received_data", int'(received_data), 0);
    chk("midreset.pulses", int'({received_data_en, parity_error, frame_error}), 0);
    wait_cycles(40);
    chk("midreset.events", evq.size(), 0);
    evq.delete();
    send_frame(RELEASE_PREFIX, 1'b1, 1'b1, FAST_HALF, 11, last_fall);
    check_frame("after_midreset", EV_DATA, 8'hF0, 8'hF0, last_fall, LAT);

    // Random frames against the frame-level rules.
    model_rd = 8'hF0;
    for (int i = 0; i < N_RANDOM; i++) begin
      rd_byte = 8'($urandom);
      rp = ($countones(rd_byte) % 2 == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 3) == 0) rp = ~rp;
      rs = ($urandom_range(0, 3) != 0);
      if (!rs) begin
        rk = EV_FERR;
      end else if ((($countones(rd_byte) + int'(rp)) % 2) == 0) begin
        rk = EV_PERR;
      end else begin
        rk = EV_DATA;
        model_rd = rd_byte;
      end
      send_frame(rd_byte, rp, rs, FAST_HALF, 11, last_fall);
      check_frame($sformatf("rand%0d", i), rk, rd_byte, model_rd, last_fall, LAT);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
